// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and read-response tag for the register file
// port arbiter.
package regfile_ctrl_pkg;

    localparam int RF_ADDR_W = 7;
    localparam int RF_DATA_W = 32;
    localparam int RF_RD_LAT = 3;
    localparam int RF_IDX_W  = 2;

    typedef struct packed {
        logic                valid;
        logic [RF_IDX_W-1:0] idx;
    } rd_tag_t;

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Client-side and register-file-side bundle of the port arbiter.
// master drives requests and read data; slave is the arbiter.
interface regfile_port_arbiter_if
    import regfile_ctrl_pkg::*;
#(
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
);

    logic [NUM_RD-1:0]        rd_valid;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_ready;
    logic [NUM_RD-1:0]        rd_resp_valid;
    logic [DATA_W-1:0]        rd_resp_data;
    logic [NUM_WR-1:0]        wr_valid;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_WR-1:0]        wr_ready;
    logic [ADDR_W-1:0]        rf_raddr0;
    logic [ADDR_W-1:0]        rf_waddr;
    logic [DATA_W-1:0]        rf_wdata;
    logic                     rf_wena;
    logic [DATA_W-1:0]        rf_rdata0;
    logic                     busy;

    modport master (
        output rd_valid, rd_addr, wr_valid, wr_addr, wr_data, rf_rdata0,
        input  rd_ready, rd_resp_valid, rd_resp_data, wr_ready,
        input  rf_raddr0, rf_waddr, rf_wdata, rf_wena, busy
    );

    modport slave (
        input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data, rf_rdata0,
        output rd_ready, rd_resp_valid, rd_resp_data, wr_ready,
        output rf_raddr0, rf_waddr, rf_wdata, rf_wena, busy
    );

endinterface

// File: rtl/regfile_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or
// after the priority pointer; pointer moves past each winner.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;
    logic          w_found;

    // First pass covers [ptr, N-1], second pass wraps to [0, ptr-1].
    always_comb begin
        o_grant   = '0;
        w_found   = 1'b0;
        w_ptr_nxt = r_ptr;
        for (int k = 0; k < N; k++) begin
            if (!w_found && i_req[k] && k >= int'(r_ptr)) begin
                o_grant[k] = 1'b1;
                w_found    = 1'b1;
                w_ptr_nxt  = (k == N - 1) ? '0 : PW'(k + 1);
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!w_found && i_req[k] && k < int'(r_ptr)) begin
                o_grant[k] = 1'b1;
                w_found    = 1'b1;
                w_ptr_nxt  = (k == N - 1) ? '0 : PW'(k + 1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_en && w_found) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares one read and one write register file port among several
// clients and routes read data back through a latency-matched tag pipe.
module regfile_port_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W,
    parameter int RD_LAT = RF_RD_LAT
) (
    input logic                  clock,
    input logic                  reset_n,
    regfile_port_arbiter_if.slave bus
);

    logic [NUM_RD-1:0]   w_rd_gnt;
    logic [NUM_WR-1:0]   w_wr_gnt;
    logic [RF_IDX_W-1:0] w_rd_idx;
    logic [ADDR_W-1:0]   w_raddr;
    logic [ADDR_W-1:0]   w_waddr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_wr_any;
    logic [NUM_RD-1:0]   w_resp;
    logic                w_tag_busy;
    rd_tag_t             w_rd_tag;
    rd_tag_t             r_tag [RD_LAT];

    rr_arbiter #(.N(NUM_RD)) u_rd_arb (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_req   (bus.rd_valid),
        .i_en    (|bus.rd_valid),
        .o_grant (w_rd_gnt)
    );

    rr_arbiter #(.N(NUM_WR)) u_wr_arb (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_req   (bus.wr_valid),
        .i_en    (|bus.wr_valid),
        .o_grant (w_wr_gnt)
    );

    always_comb begin
        w_rd_idx = '0;
        w_raddr  = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (w_rd_gnt[i]) begin
                w_rd_idx = RF_IDX_W'(i);
                w_raddr  = bus.rd_addr[i*ADDR_W +: ADDR_W];
            end
        end
        w_rd_tag.valid = |w_rd_gnt;
        w_rd_tag.idx   = w_rd_idx;
    end

    always_comb begin
        w_wr_any = 1'b0;
        w_waddr  = '0;
        w_wdata  = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (w_wr_gnt[i]) begin
                w_wr_any = 1'b1;
                w_waddr  = bus.wr_addr[i*ADDR_W +: ADDR_W];
                w_wdata  = bus.wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Tag pipe depth equals the register file read latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= w_rd_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_comb begin
        w_resp     = '0;
        w_tag_busy = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_resp[i] = r_tag[RD_LAT-1].valid &&
                        (r_tag[RD_LAT-1].idx == RF_IDX_W'(i));
        end
        for (int i = 0; i < RD_LAT; i++) begin
            w_tag_busy = w_tag_busy | r_tag[i].valid;
        end
    end

    assign bus.rd_ready      = w_rd_gnt;
    assign bus.wr_ready      = w_wr_gnt;
    assign bus.rf_raddr0     = w_raddr;
    assign bus.rf_wena       = w_wr_any;
    assign bus.rf_waddr      = w_waddr;
    assign bus.rf_wdata      = w_wdata;
    assign bus.rd_resp_valid = w_resp;
    assign bus.rd_resp_data  = bus.rf_rdata0;
    assign bus.busy          = (|bus.rd_valid) | (|bus.wr_valid) | w_tag_busy;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a 3-cycle register
// file model behind the rf_* port.
module tb_regfile_port_arbiter;
    import regfile_ctrl_pkg::*;

    localparam int NR = 2;
    localparam int NW = 2;
    localparam int AW = RF_ADDR_W;
    localparam int DW = RF_DATA_W;

    logic clock = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;

    regfile_port_arbiter_if #(
        .NUM_RD(NR), .NUM_WR(NW), .ADDR_W(AW), .DATA_W(DW)
    ) bus ();

    regfile_port_arbiter #(
        .NUM_RD(NR), .NUM_WR(NW), .ADDR_W(AW), .DATA_W(DW),
        .RD_LAT(RF_RD_LAT)
    ) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Register file model: address sampled at t, data in cycle t+3,
    // reflecting writes committed at or before the edge ending t+1.
    logic [DW-1:0] mem [1<<AW];
    logic [AW-1:0] a1, a2;
    logic          pre_we;
    logic [AW-1:0] pre_a;
    logic [DW-1:0] pre_d;

    always @(posedge clock) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (bus.rf_wena) mem[bus.rf_waddr] <= bus.rf_wdata;
        a1 <= bus.rf_raddr0;
        a2 <= a1;
        bus.rf_rdata0 <= mem[a2];
    end

    logic [1:0] g_exp [7] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [1:0] r_exp [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.rd_valid = '0;
        bus.wr_valid = '0;
    endtask

    task automatic rd(input int c, input logic [AW-1:0] a);
        bus.rd_valid[c]          = 1'b1;
        bus.rd_addr[c*AW +: AW]  = a;
    endtask

    task automatic wr(input int c, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
        bus.wr_valid[c]          = 1'b1;
        bus.wr_addr[c*AW +: AW]  = a;
        bus.wr_data[c*DW +: DW]  = d;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        step();
        pre_we = 1'b0;
    endtask

    // Called in the cycle after a read grant; hit counts from that cycle.
    task automatic drain(input int n, input int hit, input logic [1:0] v,
                         input logic [31:0] d);
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            chk("resp_valid", 32'(bus.rd_resp_valid), (k == hit) ? 32'(v) : 32'd0);
            if (k == hit) chk("resp_data", bus.rd_resp_data, d);
            step();
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        idle();
        bus.rd_addr  = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        pre_we       = 1'b0;
        pre_a        = '0;
        pre_d        = '0;
        step();
        preload(7'd5, 32'hDEAD_BEEF);
        preload(7'd1, 32'h0000_0011);
        preload(7'd2, 32'h0000_0022);
        preload(7'd9, 32'h0000_5555);
        preload(7'd3, 32'h0000_0000);

        @(negedge clock);
        chk("rst_rd_ready", 32'(bus.rd_ready), 32'd0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("rst_resp", 32'(bus.rd_resp_valid), 32'd0);
        chk("rst_wena", 32'(bus.rf_wena), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_raddr", 32'(bus.rf_raddr0), 32'd0);
        step();
        reset_n = 1'b1;

        rd(0, 7'd5);
        @(negedge clock);
        chk("t1_ready", 32'(bus.rd_ready), 32'd1);
        chk("t1_raddr", 32'(bus.rf_raddr0), 32'd5);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        step();
        idle();
        drain(4, 3, 2'b01, 32'hDEAD_BEEF);

        rd(1, 7'd5);
        @(negedge clock);
        chk("t1b_ready", 32'(bus.rd_ready), 32'd2);
        step();
        idle();
        drain(4, 3, 2'b10, 32'hDEAD_BEEF);

        rd(0, 7'd1);
        rd(1, 7'd2);
        for (int c = 0; c < 7; c++) begin
            if (c == 4) idle();
            @(negedge clock);
            chk("rr_gnt", 32'(bus.rd_ready), 32'(g_exp[c]));
            chk("rr_resp", 32'(bus.rd_resp_valid), 32'(r_exp[c]));
            if (r_exp[c] != 2'b00)
                chk("rr_data", bus.rd_resp_data,
                    (r_exp[c] == 2'b01) ? 32'h11 : 32'h22);
            step();
        end

        rd(0, 7'd9);
        @(negedge clock);
        chk("vis_a_rd", 32'(bus.rd_ready), 32'd1);
        step();
        idle();
        wr(1, 7'd9, 32'h1234);
        @(negedge clock);
        chk("vis_a_wr", 32'(bus.wr_ready), 32'd2);
        chk("vis_a_wena", 32'(bus.rf_wena), 32'd1);
        chk("vis_a_waddr", 32'(bus.rf_waddr), 32'd9);
        chk("vis_a_wdata", bus.rf_wdata, 32'h1234);
        step();
        idle();
        drain(3, 2, 2'b01, 32'h1234);

        rd(0, 7'd9);
        @(negedge clock);
        chk("vis_b_rd", 32'(bus.rd_ready), 32'd1);
        step();
        idle();
        @(negedge clock);
        chk("vis_b_nowena", 32'(bus.rf_wena), 32'd0);
        chk("vis_b_waddr0", 32'(bus.rf_waddr), 32'd0);
        chk("vis_b_wdata0", bus.rf_wdata, 32'd0);
        step();
        wr(1, 7'd9, 32'h5678);
        @(negedge clock);
        chk("vis_b_wr", 32'(bus.wr_ready), 32'd2);
        step();
        idle();
        drain(2, 1, 2'b01, 32'h1234);

        rd(0, 7'd9);
        @(negedge clock);
        chk("vis_c_rd", 32'(bus.rd_ready), 32'd1);
        step();
        idle();
        drain(4, 3, 2'b01, 32'h5678);

        wr(0, 7'd3, 32'hA);
        wr(1, 7'd3, 32'hB);
        @(negedge clock);
        chk("ww_gnt0", 32'(bus.wr_ready), 32'd1);
        chk("ww_data0", bus.rf_wdata, 32'hA);
        step();
        bus.wr_valid[0] = 1'b0;
        @(negedge clock);
        chk("ww_gnt1", 32'(bus.wr_ready), 32'd2);
        chk("ww_data1", bus.rf_wdata, 32'hB);
        step();
        idle();
        rd(0, 7'd3);
        @(negedge clock);
        step();
        idle();
        drain(4, 3, 2'b01, 32'hB);

        rd(0, 7'd1);
        wr(0, 7'd20, 32'h77);
        @(negedge clock);
        chk("rw_rd", 32'(bus.rd_ready), 32'd1);
        chk("rw_wr", 32'(bus.wr_ready), 32'd1);
        chk("rw_wena", 32'(bus.rf_wena), 32'd1);
        chk("rw_raddr", 32'(bus.rf_raddr0), 32'd1);
        chk("rw_waddr", 32'(bus.rf_waddr), 32'd20);
        step();
        idle();
        drain(4, 3, 2'b01, 32'h11);
        rd(0, 7'd20);
        @(negedge clock);
        step();
        idle();
        drain(4, 3, 2'b01, 32'h77);

        rd(0, 7'd1);
        rd(1, 7'd2);
        @(negedge clock);
        chk("mr_gnt0", 32'(bus.rd_ready), 32'd2);
        step();
        @(negedge clock);
        chk("mr_gnt1", 32'(bus.rd_ready), 32'd1);
        step();
        idle();
        reset_n = 1'b0;
        @(negedge clock);
        chk("mr_busy_rst", 32'(bus.busy), 32'd0);
        chk("mr_resp_rst", 32'(bus.rd_resp_valid), 32'd0);
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk("mr_resp", 32'(bus.rd_resp_valid), 32'd0);
            chk("mr_busy", 32'(bus.busy), 32'd0);
            step();
        end
        rd(0, 7'd1);
        rd(1, 7'd2);
        @(negedge clock);
        chk("mr_ptr0", 32'(bus.rd_ready), 32'd1);
        step();
        idle();
        drain(4, 3, 2'b01, 32'h11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Shares the single read port and single write port of the 128×32 one-read/one-write register file among several clients. Each port has its own round-robin arbiter with a valid/ready handshake. The block tracks every granted read through a tag pipeline matched to the register file's fixed 3-cycle read latency, and returns the data to the requesting client. It sits directly in front of the register file; its `rf_*` outputs connect one-to-one to the register file ports.

## Interface
Parameters:
- `NUM_RD`, default 2: number of read clients, legal 1–4.
- `NUM_WR`, default 2: number of write clients, legal 1–4.
- `ADDR_W`, default 7: register address width.
- `DATA_W`, default 32: data width.
- `RD_LAT`, default 3: register file read latency in cycles; fixed to match the register file.

Ports:
- `clock`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rd_valid`  in  NUM_RD  per-client read request.
- `rd_addr`  in  NUM_RD*ADDR_W  per-client read address; client i uses slice [i*ADDR_W +: ADDR_W].
- `rd_ready`  out  NUM_RD  one-hot or zero read grant.
- `rd_resp_valid`  out  NUM_RD  one-hot or zero response strobe.
- `rd_resp_data`  out  DATA_W  response data, shared by all clients.
- `wr_valid`  in  NUM_WR  per-client write request.
- `wr_addr`  in  NUM_WR*ADDR_W  per-client write address.
- `wr_data`  in  NUM_WR*DATA_W  per-client write data.
- `wr_ready`  out  NUM_WR  one-hot or zero write grant.
- `rf_raddr0`  out  ADDR_W  to register file read address.
- `rf_waddr`  out  ADDR_W  to register file write address.
- `rf_wdata`  out  DATA_W  to register file write data.
- `rf_wena`  out  1  to register file write enable.
- `rf_rdata0`  in  DATA_W  from register file read data.
- `busy`  out  1  high while any read is in flight or any valid is high.

## Operation
- **Handshake.** A transfer occurs in a cycle where `valid & ready` for a client.
  - A client holds `valid` and its address/data stable until that transfer happens.
  - A client's `valid` must not depend on its `ready`.
  - `ready` is combinational from the valids and the priority pointer.
- **Round-robin arbitration.** Each port has a priority pointer, `rd_ptr` and `wr_ptr`.
  - The grant goes to the first requesting client at or after the pointer, wrapping modulo N.
  - After a grant to client k, the pointer becomes (k+1) mod N.
  - With no request, there is no grant and the pointer holds.
- **Register file drive.** The `rf_*` outputs are combinational from the grant.
  - `rf_raddr0` carries the granted read address, or 0 when there is no read grant.
  - `rf_wena` equals "any write grant". `rf_waddr` and `rf_wdata` carry the granted client's fields, or 0 when there is no write grant.
- **Response pipeline.** A tag pipeline of RD_LAT stages; each stage holds a valid bit and a client index.
  - Stage 0 loads {read granted, granted index} every cycle.
  - The final stage drives `rd_resp_valid` as a one-hot of the index when its valid bit is set.
  - `rd_resp_data` is `rf_rdata0` passed through unmodified.
  - Responses have no backpressure; clients must accept them.
- **Read and write independence.** The read and write ports arbitrate independently. One read and one write can be granted in the same cycle.
- **Write visibility.** A read granted in cycle t returns data that includes every write granted in cycles ≤ t+1. Writes granted in cycle t+2 or later are not visible to it. Writes to the same address from different cycles are applied in grant order.
- **Reset values.**
  - Pointers = 0; all tag pipeline valid bits = 0.
  - `rd_ready`, `wr_ready`, `rd_resp_valid` and `rf_wena` = 0.
  - `busy` = 0 while no valid is asserted.
- **Reset mid-operation.** All in-flight read tags are discarded and no response is issued for them. The register file contents are unaffected by this block.

## Timing
- Read: grant in cycle t → `rd_resp_valid[k]` high in cycle t+3, for exactly one cycle.
- One read grant per cycle is possible, so three reads can be in flight at once.
- Write: grant in cycle t → register file updated at the rising edge ending cycle t.
- Arbitration adds zero cycles; `ready` is asserted in the same cycle as `valid` when the client wins.
- `busy` is combinational: OR of all valids and all tag pipeline valid bits.

## Structure
- Shared package `regfile_ctrl_pkg` holds:
  - the constants `RF_ADDR_W`=7, `RF_DATA_W`=32, `RF_RD_LAT`=3;
  - the response tag struct {valid, client index}.
- Sub-module `rr_arbiter` (parameter N):
  - inputs: request vector, advance enable;
  - output: one-hot grant;
  - internal priority pointer.
  - Instantiated twice, once per port.
- The top level holds the address/data muxes and the tag pipeline.

## Test plan
- Reset, then client 0 reads addr 5 after the bench preloads 0xDEAD_BEEF → `rd_ready[0]` high in the same cycle; `rd_resp_valid`=2'b01 and `rd_resp_data`=0xDEAD_BEEF exactly 3 cycles later.
- Both read clients hold valid for 4 cycles (addrs 1 and 2) → grants alternate 0,1,0,1; responses alternate in the same order at +3; no cycle has two grants.
- Write client 1 writes 0x1234 to addr 9 in cycle t; client 0 reads addr 9 in cycle t-1 → the response returns 0x1234. The same read issued in cycle t-2 returns the old value.
- Both write clients write addr 3 (0xA, 0xB) in back-to-back grants → a subsequent read returns the value of the later grant.
- Simultaneous read and write grants to different addresses in one cycle → both complete; `rf_wena`=1 and the read response arrives on schedule.
- Assert `reset_n`=0 one cycle after two reads are granted → no `rd_resp_valid` after reset release; pointers return to 0; `busy`=0.
